// File: rtl/issue_unit.sv
// issue_unit: one-entry issue stage between decode and execute.
// Holds the architectural register file and resolves operands from
// forwarding channels, the commit port and the array, stalling on
// pending producers and dropping the held entry on flush.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   flush             kill the held instruction
//   dec_*             decode side valid/ready bundle
//   byp_*             NBYP forwarding channels (channel 0 youngest)
//   wb_*              commit write port into the register file
//   iss_*             execute side valid/ready bundle and operands
module issue_unit #(
   parameter int XLEN  = 32,
   parameter int NREG  = 32,
   parameter int NBYP  = 2,
   parameter int CTRLW = 16,
   localparam int AW   = $clog2(NREG)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 dec_valid,
   output logic                 dec_ready,
   input  logic [AW-1:0]        dec_rs1,
   input  logic [AW-1:0]        dec_rs2,
   input  logic [AW-1:0]        dec_rd,
   input  logic                 dec_we,
   input  logic [1:0]           dec_asel,
   input  logic [1:0]           dec_bsel,
   input  logic [XLEN-1:0]      dec_imm,
   input  logic [XLEN-1:0]      dec_pc,
   input  logic [4:0]           dec_shamt,
   input  logic [CTRLW-1:0]     dec_ctrl,
   input  logic [NBYP-1:0]      byp_valid,
   input  logic [NBYP-1:0]      byp_pending,
   input  logic [NBYP*AW-1:0]   byp_rd,
   input  logic [NBYP*XLEN-1:0] byp_data,
   input  logic                 wb_we,
   input  logic [AW-1:0]        wb_addr,
   input  logic [XLEN-1:0]      wb_data,
   output logic                 iss_valid,
   input  logic                 iss_ready,
   output logic [XLEN-1:0]      iss_op_a,
   output logic [XLEN-1:0]      iss_op_b,
   output logic [XLEN-1:0]      iss_rs2_data,
   output logic [AW-1:0]        iss_rd,
   output logic                 iss_we,
   output logic [XLEN-1:0]      iss_pc,
   output logic [XLEN-1:0]      iss_imm,
   output logic [CTRLW-1:0]     iss_ctrl
);

   typedef struct packed {
      logic [AW-1:0]    rs1;
      logic [AW-1:0]    rs2;
      logic [AW-1:0]    rd;
      logic             we;
      logic [1:0]       asel;
      logic [1:0]       bsel;
      logic [XLEN-1:0]  imm;
      logic [XLEN-1:0]  pc;
      logic [4:0]       shamt;
      logic [CTRLW-1:0] ctrl;
   } entry_t;

   entry_t          ent;
   logic            v;
   logic [XLEN-1:0] rf [NREG];

   logic            cap;
   logic            ret;
   logic            hz1;
   logic            hz2;
   logic            rs1_used;
   logic            hazard;
   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;

   // Returns {hazard, value}. Channels are scanned oldest to youngest
   // so the lowest matching index overrides; x0 overrides everything.
   function automatic logic [XLEN:0] resolve(
      input logic [AW-1:0]   s,
      input logic [XLEN-1:0] rfv
   );
      logic [XLEN-1:0] val;
      logic            hz;
      val = rfv;
      hz  = 1'b0;
      if (wb_we && wb_addr == s)
         val = wb_data;
      for (int i = NBYP - 1; i >= 0; i--) begin
         if (byp_valid[i] && byp_rd[i*AW +: AW] == s) begin
            hz  = byp_pending[i];
            val = byp_data[i*XLEN +: XLEN];
         end
      end
      if (s == '0) begin
         val = '0;
         hz  = 1'b0;
      end
      return {hz, val};
   endfunction

   always_comb begin
      {hz1, rs1_val} = resolve(ent.rs1, rf[ent.rs1]);
      {hz2, rs2_val} = resolve(ent.rs2, rf[ent.rs2]);
   end

   // rs2 always counts: stores and branches read it regardless of bsel.
   assign rs1_used  = (ent.asel == 2'b00) || (ent.asel == 2'b11);
   assign hazard    = (rs1_used && hz1) || hz2;
   assign iss_valid = v && !hazard;
   assign ret       = iss_valid && iss_ready;
   assign dec_ready = !v || ret;
   assign cap       = dec_valid && dec_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v   <= 1'b0;
         ent <= '0;
      end else begin
         if (flush)
            v <= 1'b0;
         else if (cap)
            v <= 1'b1;
         else if (ret)
            v <= 1'b0;
         if (cap && !flush) begin
            ent.rs1   <= dec_rs1;
            ent.rs2   <= dec_rs2;
            ent.rd    <= dec_rd;
            ent.we    <= dec_we;
            ent.asel  <= dec_asel;
            ent.bsel  <= dec_bsel;
            ent.imm   <= dec_imm;
            ent.pc    <= dec_pc;
            ent.shamt <= dec_shamt;
            ent.ctrl  <= dec_ctrl;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++)
            rf[i] <= '0;
      end else if (wb_we && wb_addr != '0) begin
         rf[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      iss_op_a = rs1_val;
      unique case (ent.asel)
         2'b01:   iss_op_a = ent.pc;
         2'b10:   iss_op_a = '0;
         default: iss_op_a = rs1_val;
      endcase
   end

   always_comb begin
      iss_op_b = rs2_val;
      unique case (ent.bsel)
         2'b01:   iss_op_b = ent.imm;
         2'b10:   iss_op_b = {{(XLEN-5){1'b0}}, ent.shamt};
         default: iss_op_b = rs2_val;
      endcase
   end

   assign iss_rs2_data = rs2_val;
   assign iss_rd       = ent.rd;
   assign iss_we       = ent.we;
   assign iss_pc       = ent.pc;
   assign iss_imm      = ent.imm;
   assign iss_ctrl     = ent.ctrl;

endmodule

// File: tb/tb_issue_unit.sv
// tb_issue_unit: scoreboard bench for issue_unit.
// Expected operands are queued at decode and compared at issue.
module tb_issue_unit;

   localparam int XLEN  = 32;
   localparam int NREG  = 32;
   localparam int NBYP  = 2;
   localparam int CTRLW = 16;
   localparam int AW    = 5;

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic                 flush = 1'b0;
   logic                 dec_valid = 1'b0;
   logic                 dec_ready;
   logic [AW-1:0]        dec_rs1 = '0;
   logic [AW-1:0]        dec_rs2 = '0;
   logic [AW-1:0]        dec_rd = '0;
   logic                 dec_we = 1'b0;
   logic [1:0]           dec_asel = '0;
   logic [1:0]           dec_bsel = '0;
   logic [XLEN-1:0]      dec_imm = '0;
   logic [XLEN-1:0]      dec_pc = '0;
   logic [4:0]           dec_shamt = '0;
   logic [CTRLW-1:0]     dec_ctrl = '0;
   logic [NBYP-1:0]      byp_valid = '0;
   logic [NBYP-1:0]      byp_pending = '0;
   logic [NBYP*AW-1:0]   byp_rd = '0;
   logic [NBYP*XLEN-1:0] byp_data = '0;
   logic                 wb_we = 1'b0;
   logic [AW-1:0]        wb_addr = '0;
   logic [XLEN-1:0]      wb_data = '0;
   logic                 iss_valid;
   logic                 iss_ready = 1'b1;
   logic [XLEN-1:0]      iss_op_a;
   logic [XLEN-1:0]      iss_op_b;
   logic [XLEN-1:0]      iss_rs2_data;
   logic [AW-1:0]        iss_rd;
   logic                 iss_we;
   logic [XLEN-1:0]      iss_pc;
   logic [XLEN-1:0]      iss_imm;
   logic [CTRLW-1:0]     iss_ctrl;

   typedef struct {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [AW-1:0]   rd;
   } exp_t;

   exp_t sbq[$];
   exp_t e;
   int   checks = 0;
   int   failures = 0;

   issue_unit #(
      .XLEN(XLEN), .NREG(NREG), .NBYP(NBYP), .CTRLW(CTRLW)
   ) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
      .dec_we(dec_we), .dec_asel(dec_asel), .dec_bsel(dec_bsel),
      .dec_imm(dec_imm), .dec_pc(dec_pc), .dec_shamt(dec_shamt),
      .dec_ctrl(dec_ctrl),
      .byp_valid(byp_valid), .byp_pending(byp_pending),
      .byp_rd(byp_rd), .byp_data(byp_data),
      .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .iss_valid(iss_valid), .iss_ready(iss_ready),
      .iss_op_a(iss_op_a), .iss_op_b(iss_op_b),
      .iss_rs2_data(iss_rs2_data), .iss_rd(iss_rd), .iss_we(iss_we),
      .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_ctrl(iss_ctrl)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // Drive one decode transfer; returns at posedge+1 of the capture edge.
   task automatic send(
      input logic [AW-1:0]    rs1,
      input logic [AW-1:0]    rs2,
      input logic [AW-1:0]    rd,
      input logic [1:0]       asel,
      input logic [1:0]       bsel,
      input logic [XLEN-1:0]  imm,
      input logic [XLEN-1:0]  pc,
      input logic [4:0]       shamt,
      input logic [CTRLW-1:0] ctrl
   );
      int n;
      dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_we = 1'b1;
      dec_asel = asel; dec_bsel = bsel; dec_imm = imm; dec_pc = pc;
      dec_shamt = shamt; dec_ctrl = ctrl; dec_valid = 1'b1;
      @(negedge clk);
      n = 0;
      while (!dec_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (dec_ready !== 1'b1) begin
         failures++;
         $display("FAIL send_ready got=%b want=1", dec_ready);
      end
      @(posedge clk); #1;
      dec_valid = 1'b0;
   endtask

   task automatic wbw(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
      wb_we = 1'b1; wb_addr = a; wb_data = d;
      @(posedge clk); #1;
      wb_we = 1'b0;
   endtask

   task automatic test_reset;
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({iss_valid, dec_ready, iss_we} !== 3'b010) begin
         failures++;
         $display("FAIL reset_flags got=%b want=010",
                  {iss_valid, dec_ready, iss_we});
      end
      checks++;
      if ({iss_op_a, iss_op_b} !== '0) begin
         failures++;
         $display("FAIL reset_ops got=%h/%h want=0/0", iss_op_a, iss_op_b);
      end
      checks++;
      if ({iss_rd, iss_pc, iss_imm, iss_ctrl} !== '0) begin
         failures++;
         $display("FAIL reset_fields rd=%h pc=%h imm=%h ctrl=%h want=0",
                  iss_rd, iss_pc, iss_imm, iss_ctrl);
      end
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_single;
      wbw(5'd1, 32'd5);
      wbw(5'd2, 32'd9);
      iss_ready = 1'b1;
      sbq.push_back('{a: 32'd5, b: 32'h10, rd: 5'd7});
      send(5'd1, 5'd2, 5'd7, 2'b00, 2'b01, 32'h10, 32'h40, 5'd0, 16'h1234);
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b1) begin
         failures++;
         $display("FAIL single_latency valid=%b want=1", iss_valid);
      end
      e = sbq.pop_front();
      checks++;
      if (iss_op_a !== e.a || iss_op_b !== e.b || iss_rd !== e.rd) begin
         failures++;
         $display("FAIL single_ops a=%h b=%h rd=%h want %h %h %h",
                  iss_op_a, iss_op_b, iss_rd, e.a, e.b, e.rd);
      end
      checks++;
      if ({iss_we, iss_ctrl, iss_rs2_data} !== {1'b1, 16'h1234, 32'd9}) begin
         failures++;
         $display("FAIL single_pass we=%b ctrl=%h rs2=%h want 1 1234 9",
                  iss_we, iss_ctrl, iss_rs2_data);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_retire valid=%b want=0", iss_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_bypass;
      iss_ready = 1'b0;
      send(5'd3, 5'd0, 5'd1, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0);
      byp_valid = 2'b11; byp_pending = 2'b00;
      byp_rd = {5'd3, 5'd3};
      byp_data = {32'hB, 32'hA};
      wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'hC;
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b1 || iss_op_a !== 32'hA) begin
         failures++;
         $display("FAIL byp_ch0 v=%b a=%h want 1 0000000a", iss_valid, iss_op_a);
      end
      @(posedge clk); #1;
      byp_valid = 2'b10;
      @(negedge clk);
      checks++;
      if (iss_op_a !== 32'hB) begin
         failures++;
         $display("FAIL byp_ch1 a=%h want 0000000b", iss_op_a);
      end
      @(posedge clk); #1;
      byp_valid = 2'b00;
      @(negedge clk);
      checks++;
      if (iss_op_a !== 32'hC) begin
         failures++;
         $display("FAIL byp_wb a=%h want 0000000c", iss_op_a);
      end
      @(posedge clk); #1;
      wb_we = 1'b0;
      @(negedge clk);
      checks++;
      if (iss_op_a !== 32'hC) begin
         failures++;
         $display("FAIL byp_rf a=%h want 0000000c", iss_op_a);
      end
      @(posedge clk); #1;
      iss_ready = 1'b1;
      @(posedge clk); #1;
      byp_data = '0; byp_rd = '0;
   endtask

   task automatic test_load_use;
      iss_ready = 1'b1;
      byp_valid = 2'b01; byp_pending = 2'b01;
      byp_rd = {5'd0, 5'd4};
      byp_data = '0;
      send(5'd4, 5'd0, 5'd8, 2'b00, 2'b01, 32'h1, 32'h0, 5'd0, 16'h0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (iss_valid !== 1'b0 || dec_ready !== 1'b0) begin
            failures++;
            $display("FAIL lu_stall%0d valid=%b ready=%b want 0 0",
                     k, iss_valid, dec_ready);
         end
      end
      @(posedge clk); #1;
      byp_pending = 2'b00;
      byp_data = {32'h0, 32'h77};
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b1 || iss_op_a !== 32'h77) begin
         failures++;
         $display("FAIL lu_release valid=%b a=%h want 1 00000077",
                  iss_valid, iss_op_a);
      end
      @(posedge clk); #1;
      byp_valid = '0; byp_data = '0; byp_rd = '0;
   endtask

   task automatic test_x0_modes;
      wbw(5'd0, 32'hFF);
      wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFF;
      byp_valid = 2'b01; byp_pending = 2'b01;
      byp_rd = {5'd0, 5'd0};
      send(5'd0, 5'd0, 5'd9, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0);
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b1) begin
         failures++;
         $display("FAIL x0_nostall valid=%b want=1", iss_valid);
      end
      checks++;
      if ({iss_op_a, iss_op_b, iss_rs2_data} !== '0) begin
         failures++;
         $display("FAIL x0_zero a=%h b=%h rs2=%h want 0",
                  iss_op_a, iss_op_b, iss_rs2_data);
      end
      @(posedge clk); #1;
      wb_we = 1'b0; byp_valid = '0; byp_pending = '0;
      sbq.push_back('{a: 32'h100, b: 32'd31, rd: 5'd10});
      send(5'd5, 5'd0, 5'd10, 2'b01, 2'b10, 32'h55, 32'h100, 5'd31, 16'h0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (iss_valid !== 1'b1 || iss_op_a !== e.a || iss_op_b !== e.b) begin
         failures++;
         $display("FAIL modes v=%b a=%h b=%h want 1 %h %h",
                  iss_valid, iss_op_a, iss_op_b, e.a, e.b);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_stream;
      int sent;
      int got;
      bit ready_pat[4];
      ready_pat = '{1'b1, 1'b0, 1'b1, 1'b1};
      sent = 0;
      got = 0;
      for (int c = 0; c < 20 && got < 4; c++) begin
         iss_ready = ready_pat[c % 4];
         dec_valid = (sent < 4);
         dec_rs1 = '0; dec_rs2 = '0; dec_we = 1'b1;
         dec_asel = 2'b01; dec_bsel = 2'b01;
         dec_pc = 32'h200 + 32'(sent * 4);
         dec_imm = 32'h30 + 32'(sent);
         dec_rd = 5'(10 + sent);
         @(negedge clk);
         if (iss_valid && sbq.size() > 0) begin
            e = sbq[0];
            checks++;
            if (iss_op_a !== e.a || iss_op_b !== e.b || iss_rd !== e.rd) begin
               failures++;
               $display("FAIL stream_out c=%0d a=%h b=%h rd=%h want %h %h %h",
                        c, iss_op_a, iss_op_b, iss_rd, e.a, e.b, e.rd);
            end
            if (iss_ready) begin
               void'(sbq.pop_front());
               got++;
            end else begin
               checks++;
               if (dec_ready !== 1'b0) begin
                  failures++;
                  $display("FAIL stream_bp ready=%b want=0", dec_ready);
               end
            end
         end
         if (dec_valid && dec_ready) begin
            sbq.push_back('{a: dec_pc, b: dec_imm, rd: dec_rd});
            sent++;
         end
         @(posedge clk); #1;
      end
      dec_valid = 1'b0;
      iss_ready = 1'b1;
      checks++;
      if (got != 4 || sbq.size() != 0) begin
         failures++;
         $display("FAIL stream_count got=%0d left=%0d want 4 0",
                  got, sbq.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic test_flush;
      iss_ready = 1'b1;
      dec_rs1 = '0; dec_rs2 = '0; dec_rd = 5'd20; dec_we = 1'b1;
      dec_asel = 2'b01; dec_bsel = 2'b01;
      dec_pc = 32'hAAA; dec_imm = 32'h1;
      dec_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      checks++;
      if (dec_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_ready ready=%b want=1", dec_ready);
      end
      @(posedge clk); #1;
      dec_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_kill valid=%b want=0", iss_valid);
      end
      @(posedge clk); #1;
      sbq.push_back('{a: 32'h300, b: 32'h44, rd: 5'd21});
      send(5'd0, 5'd0, 5'd21, 2'b01, 2'b01, 32'h44, 32'h300, 5'd0, 16'h0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (iss_valid !== 1'b1 || iss_op_a !== e.a || iss_op_b !== e.b ||
          iss_rd !== e.rd) begin
         failures++;
         $display("FAIL flush_next v=%b a=%h b=%h rd=%h want 1 %h %h %h",
                  iss_valid, iss_op_a, iss_op_b, iss_rd, e.a, e.b, e.rd);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_stall;
      iss_ready = 1'b1;
      byp_valid = 2'b01; byp_pending = 2'b01;
      byp_rd = {5'd0, 5'd6};
      send(5'd6, 5'd0, 5'd22, 2'b00, 2'b01, 32'h99, 32'h400, 5'd3, 16'hFFFF);
      @(negedge clk);
      checks++;
      if (iss_valid !== 1'b0) begin
         failures++;
         $display("FAIL rs_stall valid=%b want=0", iss_valid);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({iss_valid, dec_ready, iss_we} !== 3'b010 ||
          {iss_rd, iss_pc, iss_imm, iss_ctrl} !== '0 ||
          {iss_op_a, iss_op_b} !== '0) begin
         failures++;
         $display("FAIL rs_outputs v=%b r=%b we=%b rd=%h pc=%h imm=%h ctrl=%h a=%h b=%h want reset",
                  iss_valid, dec_ready, iss_we, iss_rd, iss_pc, iss_imm,
                  iss_ctrl, iss_op_a, iss_op_b);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      byp_valid = '0; byp_pending = '0; byp_rd = '0;
      sbq.push_back('{a: 32'd0, b: 32'd0, rd: 5'd23});
      send(5'd1, 5'd2, 5'd23, 2'b00, 2'b00, 32'h0, 32'h0, 5'd0, 16'h0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (iss_valid !== 1'b1 || iss_op_a !== e.a || iss_op_b !== e.b) begin
         failures++;
         $display("FAIL rs_rfclear v=%b a=%h b=%h want 1 %h %h",
                  iss_valid, iss_op_a, iss_op_b, e.a, e.b);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_bypass();
      test_load_use();
      test_x0_modes();
      test_stream();
      test_flush();
      test_reset_stall();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
